txn_fifo: RTL
=============

# txn_fifo

Transaction buffer sitting between the stimulus-facing port of the DUT wrapper and its processing core. It accepts write-enable transactions from the driver side without backpressure, stores up to DEPTH entries, and presents them downstream on a first-word-fall-through valid/ready port. Overflow events are flagged with a sticky error bit so the monitor can report them.

## Interface
- DATA_W, default 8: data word width in bits.
- DEPTH, default 8: number of entries; power of two, ≥ 2.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset immediately, release is synchronous to clk.
- wr_en  input  1  write request from upstream; no backpressure.
- wr_data  input  DATA_W  word written when wr_en is accepted.
- full  output  1  registered; 1 when count == DEPTH.
- rd_valid  output  1  1 when count != 0.
- rd_data  output  DATA_W  head entry, valid only while rd_valid = 1.
- rd_ready  input  1  downstream accepts head when rd_valid = 1.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on any write request while full.
- clear_ovf  input  1  synchronous clear of overflow.

## Operation
- Storage: DEPTH × DATA_W array, zeroed by reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- push = wr_en && !full, using full as registered at the start of the cycle. On push: mem[wr_ptr] <= wr_data, wr_ptr increments.
- pop = rd_valid && rd_ready. On pop: rd_ptr increments.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- full <= (next count == DEPTH). rd_valid is derived from count (count != 0).
- rd_data = mem[rd_ptr], combinational from the registered pointer (FWFT).
- Write while full: the word is dropped and overflow is set to 1. This applies even if a pop happens in the same cycle; the slot freed by that pop is not backfilled.
- overflow: cleared by clear_ovf. If a set event and clear_ovf occur in the same cycle, set wins.
- No bypass: a write into an empty FIFO cannot be popped in the same cycle.
- Order is strictly preserved; no entry is duplicated or lost except dropped overflow writes.

## Timing
- Reset values (while reset = 0): count = 0, full = 0, rd_valid = 0, overflow = 0, rd_data = 0, pointers = 0.
- Reset asserted mid-operation clears all state asynchronously; contents are discarded.
- Write-to-visible latency is 1 cycle. After the push edge, rd_valid = 1 and rd_data = the written word, in the same cycle.
- Pop takes effect at the edge where rd_valid && rd_ready. The next head (or rd_valid = 0) is visible right after that edge.
- full rises on the edge that makes count == DEPTH. It falls on the edge of the first pop without a simultaneous push.
- The overflow flag is visible the cycle after the offending wr_en edge.
- Simultaneous push and pop at 0 < count < DEPTH: count holds; both pointers advance.
- Pointer wrap from DEPTH−1 to 0 has no effect on count or flags.

## Test plan
- Reset, then idle: count = 0, rd_valid = 0, full = 0, overflow = 0, rd_data = 0. Assert reset again mid-stream after 3 writes: all outputs return to these values at once.
- Write 0x11, 0x22, 0x33 on back-to-back cycles with rd_ready = 0. Expect count 1→2→3 and rd_data = 0x11. Then hold rd_ready = 1 for 3 cycles: rd_data is 0x11, 0x22, 0x33, then rd_valid = 0.
- Fill with 8 writes (DEPTH = 8): full = 1, count = 8. A 9th write of 0xAA is dropped and overflow = 1. Drain: 8 words in order, no 0xAA. Pulse clear_ovf: overflow = 0.
- At full, assert wr_en (0xBB) and a pop in the same cycle. Expect the write dropped, overflow = 1, count = 7. clear_ovf together with another write-while-full leaves overflow = 1.
- Count = 4 with continuous simultaneous push/pop for 20 cycles (pointers wrap twice). Expect count constant at 4 and output sequence = input sequence delayed by 4 entries.
- Empty FIFO, wr_en = 1 and rd_ready = 1 in the same cycle. No pop that cycle; next cycle rd_valid = 1, and with rd_ready still 1 the pop happens, giving count 0 afterwards.

Source files
------------

// File: rtl/txn_fifo.sv
// txn_fifo: first-word-fall-through transaction buffer with no write backpressure.
// Writes that arrive while full are dropped and latch a sticky overflow flag
// until it is cleared.
module txn_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;

    // The registered full is used for the push decision, so a pop in the
    // same cycle never frees a slot for the incoming word.
    assign push     = wr_en && !full;
    assign pop      = rd_valid && rd_ready;
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    // Next occupancy: +1 on push only, -1 on pop only, else unchanged.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage array; cleared on reset so rd_data reads zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset on purpose: rd_data must read 0 after reset, which
            // costs flops instead of RAM; drop this loop if the array must map to RAM.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Sticky overflow: a write while full sets it and takes priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
